// File: rtl/led_reg_monitor.sv
// led_reg_monitor: shows one register of a CPU bank on the LEDs, chosen by debounced switches,
// with live, freeze (snapshot), auto-scan and watch (change pulse) display modes.
module led_reg_monitor #(
    parameter int NUM_REGS     = 8,
    parameter int DATA_W       = 16,
    parameter int LED_W        = 16,
    parameter int SEL_W        = 3,
    parameter int DEBOUNCE_CYC = 1000000,
    parameter int SCAN_DIV     = 100000000
) (
    input  logic                       clk_100mhz,
    input  logic                       btn_reset_n,
    input  logic [SEL_W-1:0]           SW,
    input  logic [1:0]                 mode,
    input  logic [NUM_REGS*DATA_W-1:0] regs_flat,
    output logic [LED_W-1:0]           LED,
    output logic [SEL_W-1:0]           sel_idx,
    output logic                       sel_err,
    output logic                       change_pulse
);
    localparam int NS  = 2**SEL_W;
    localparam int CW  = $clog2(DEBOUNCE_CYC + 1);
    localparam int SCW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
    localparam int MW  = DATA_W < LED_W ? DATA_W : LED_W;
    localparam logic [SEL_W:0]   NREG  = (SEL_W+1)'(NUM_REGS);
    localparam logic [SEL_W-1:0] LAST  = SEL_W'(NUM_REGS - 1);
    localparam logic [CW-1:0]    DEB   = CW'(DEBOUNCE_CYC);
    localparam logic [SCW-1:0]   SLAST = SCW'(SCAN_DIV - 1);
    localparam logic [1:0] M_FRZ = 2'b01, M_SCAN = 2'b10, M_WATCH = 2'b11;

    logic [SEL_W-1:0]  r_sync1, r_sync2, r_cand, r_sel_q, r_prev_sel, r_scan_idx, r_sel_idx;
    logic [CW-1:0]     r_cnt;
    logic [SCW-1:0]    r_scan_cnt;
    logic [1:0]        r_mode_q;
    logic [DATA_W-1:0] r_snap [NS];
    logic [DATA_W-1:0] r_prev;
    logic [LED_W-1:0]  r_led;
    logic              r_sel_err, r_pulse;

    logic [DATA_W-1:0] w_regs [NS];
    logic [DATA_W-1:0] w_src, w_cur;
    logic [LED_W-1:0]  w_disp;
    logic [SEL_W-1:0]  w_scan_step, w_scan_nxt, w_idx;
    logic              w_entry, w_scan, w_tick, w_oor, w_stable, w_pulse;

    // Unpopulated select codes read as zero so out-of-range indexing stays benign
    for (genvar g = 0; g < NS; g++) begin : g_unpack
        if (g < NUM_REGS) begin : g_on
            assign w_regs[g] = regs_flat[g*DATA_W +: DATA_W];
        end else begin : g_off
            assign w_regs[g] = '0;
        end
    end

    always_comb begin
        w_entry     = mode != r_mode_q;
        w_scan      = mode == M_SCAN;
        w_tick      = r_scan_cnt == SLAST;
        w_scan_step = r_scan_idx == LAST ? '0 : r_scan_idx + 1'b1;
        w_scan_nxt  = w_entry ? '0 : w_tick ? w_scan_step : r_scan_idx;
        w_oor       = {1'b0, r_sel_q} >= NREG;
        w_stable    = r_sync2 == r_cand;
        w_idx       = w_scan ? w_scan_nxt : r_sel_q;
        // On the freeze entry edge the snapshot is still being loaded, so show the live bus
        w_src       = (mode == M_FRZ && !w_entry) ? r_snap[w_idx] : w_regs[w_idx];
        w_disp      = '0;
        w_disp[MW-1:0] = w_src[MW-1:0];
        w_cur       = w_regs[r_sel_q];
        w_pulse     = mode == M_WATCH && !w_entry && !w_oor && r_prev_sel == r_sel_q && w_cur != r_prev;
    end

    always_ff @(posedge clk_100mhz or negedge btn_reset_n) begin
        if (!btn_reset_n) begin
            r_sync1    <= '0;
            r_sync2    <= '0;
            r_cand     <= '0;
            r_cnt      <= '0;
            r_sel_q    <= '0;
            r_mode_q   <= '0;
            r_snap     <= '{default: '0};
            r_scan_cnt <= '0;
            r_scan_idx <= '0;
            r_prev     <= '0;
            r_prev_sel <= '0;
            r_led      <= '0;
            r_sel_idx  <= '0;
            r_sel_err  <= 1'b0;
            r_pulse    <= 1'b0;
        end else begin
            r_sync1    <= SW;
            r_sync2    <= r_sync1;
            r_cand     <= r_sync2;
            r_cnt      <= !w_stable ? CW'(1) : r_cnt == DEB ? r_cnt : r_cnt + 1'b1;
            if (w_stable && r_cnt == DEB)
                r_sel_q <= r_cand;
            r_mode_q   <= mode;
            if (mode == M_FRZ && w_entry)
                r_snap <= w_regs;
            r_scan_cnt <= (!w_scan || w_entry || w_tick) ? '0 : r_scan_cnt + 1'b1;
            r_scan_idx <= w_scan ? w_scan_nxt : '0;
            r_prev     <= w_cur;
            r_prev_sel <= r_sel_q;
            r_led      <= (!w_scan && w_oor) ? '0 : w_disp;
            r_sel_idx  <= w_idx;
            r_sel_err  <= !w_scan && w_oor;
            r_pulse    <= w_pulse;
        end
    end

    assign LED          = r_led;
    assign sel_idx      = r_sel_idx;
    assign sel_err      = r_sel_err;
    assign change_pulse = r_pulse;
endmodule

// File: tb/tb_led_reg_monitor.sv
// tb_led_reg_monitor: directed table and corner sequences, then random run against a history-based model.
module tb_led_reg_monitor;
    localparam int DEB = 4;
    localparam int DIV = 10;
    localparam int NR  = 3000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic [2:0]   sw;
    logic [1:0]   mode;
    logic [127:0] regs;
    logic [15:0]  led8, led6;
    logic [2:0]   idx8, idx6;
    logic         err8, err6, pul8, pul6;
    int total = 0;
    int bad   = 0;

    led_reg_monitor #(.NUM_REGS(8), .DATA_W(16), .LED_W(16), .SEL_W(3), .DEBOUNCE_CYC(DEB), .SCAN_DIV(DIV)) dut8 (
        .clk_100mhz(clk), .btn_reset_n(rst_n), .SW(sw), .mode(mode), .regs_flat(regs),
        .LED(led8), .sel_idx(idx8), .sel_err(err8), .change_pulse(pul8));

    led_reg_monitor #(.NUM_REGS(6), .DATA_W(16), .LED_W(16), .SEL_W(3), .DEBOUNCE_CYC(DEB), .SCAN_DIV(DIV)) dut6 (
        .clk_100mhz(clk), .btn_reset_n(rst_n), .SW(sw), .mode(mode), .regs_flat(regs[95:0]),
        .LED(led6), .sel_idx(idx6), .sel_err(err6), .change_pulse(pul6));

    typedef struct {
        logic [2:0]  sw;
        logic [15:0] led8;
        logic [15:0] led6;
        logic        err6;
    } vec_t;
    vec_t tbl [8];

    // Recorded inputs per edge since reset release, and the accepted select after each edge
    logic [2:0]   h_sw [NR];
    logic [1:0]   h_m  [NR];
    logic [127:0] h_r  [NR];
    logic [2:0]   h_s  [NR];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_reg(input int i, input logic [15:0] v);
        regs[i*16 +: 16] = v;
    endtask

    function automatic logic [15:0] rg(input logic [127:0] r, input int i);
        return r[i*16 +: 16];
    endfunction

    function automatic logic [2:0] sw_at(input int i);
        return i < 0 ? 3'd0 : h_sw[i];
    endfunction

    function automatic logic [2:0] s_at(input int i);
        return i < 0 ? 3'd0 : h_s[i];
    endfunction

    function automatic logic [1:0] m_at(input int i);
        return i < 0 ? 2'd0 : h_m[i];
    endfunction

    function automatic logic [127:0] r_at(input int i);
        return i < 0 ? 128'd0 : h_r[i];
    endfunction

    // A switch value is accepted once DEB+1 consecutive synchronised samples agree
    task automatic model_sel(input int k);
        logic eq;
        eq = 1'b1;
        for (int j = k - 2 - DEB; j <= k - 2; j++)
            if (sw_at(j) != sw_at(k - 2)) eq = 1'b0;
        h_s[k] = eq ? sw_at(k - 2) : s_at(k - 1);
    endtask

    task automatic model_out(input int k, input int n, output logic [15:0] led, output logic [2:0] idx,
                             output logic err, output logic pul);
        int e, id;
        logic [1:0] m;
        logic [2:0] sp;
        m  = h_m[k];
        sp = s_at(k - 1);
        e  = k;
        while (e > 0 && h_m[e-1] == m) e--;
        if (m == 2'd2) begin
            id  = ((k - e) / DIV) % n;
            led = rg(h_r[k], id);
            idx = 3'(id);
            err = 1'b0;
        end else begin
            idx = sp;
            err = int'(sp) >= n;
            led = err ? 16'd0 : rg(m == 2'd1 ? h_r[e] : h_r[k], int'(sp));
        end
        pul = m == 2'd3 && m_at(k - 1) == 2'd3 && !(int'(sp) >= n) && sp == s_at(k - 2)
              && rg(h_r[k], int'(sp)) != rg(r_at(k - 1), int'(sp));
    endtask

    initial begin
        int cnt, hold, ri;
        logic [15:0] el;
        logic [2:0]  ei;
        logic        ee, ep;

        tbl[0] = '{3'd3, 16'h1333, 16'h1333, 1'b0};
        tbl[1] = '{3'd0, 16'h1000, 16'h1000, 1'b0};
        tbl[2] = '{3'd7, 16'h1777, 16'h0000, 1'b1};
        tbl[3] = '{3'd5, 16'h1555, 16'h1555, 1'b0};
        tbl[4] = '{3'd6, 16'h1666, 16'h0000, 1'b1};
        tbl[5] = '{3'd1, 16'h1111, 16'h1111, 1'b0};
        tbl[6] = '{3'd4, 16'h1444, 16'h1444, 1'b0};
        tbl[7] = '{3'd2, 16'h1222, 16'h1222, 1'b0};

        // Reset and switch-to-LED latency
        rst_n = 1'b0; sw = 3'd0; mode = 2'd0; regs = '0;
        set_reg(5, 16'h00A5);
        cyc(3);
        chk("reset_led", 32'(led8), 32'h0);
        chk("reset_idx", 32'(idx8), 32'h0);
        chk("reset_err", 32'(err8), 32'h0);
        rst_n = 1'b1;
        cyc(10);
        chk("idle_led", 32'(led8), 32'h0);
        sw = 3'd5;
        cyc(6);
        chk("lat_led_t5", 32'(led8), 32'h0);
        cyc(1);
        chk("lat_led_t6", 32'(led8), 32'h0);
        chk("lat_idx_t6", 32'(idx8), 32'h0);
        cyc(1);
        chk("lat_led_t7", 32'(led8), 32'h00A5);
        chk("lat_idx_t7", 32'(idx8), 32'h5);

        // Table of live-mode selections on both bank sizes
        for (int i = 0; i < 8; i++) set_reg(i, 16'h1000 + 16'(i) * 16'h0111);
        for (int i = 0; i < 8; i++) begin
            sw = tbl[i].sw;
            cyc(8);
            chk("tbl_led8", 32'(led8), 32'(tbl[i].led8));
            chk("tbl_idx8", 32'(idx8), 32'(tbl[i].sw));
            chk("tbl_err8", 32'(err8), 32'h0);
            chk("tbl_led6", 32'(led6), 32'(tbl[i].led6));
            chk("tbl_err6", 32'(err6), 32'(tbl[i].err6));
        end

        // Short switch glitch must be rejected
        set_reg(3, 16'h1234); set_reg(6, 16'h6666);
        sw = 3'd3;
        cyc(8);
        sw = 3'd6;
        for (int i = 0; i < 12; i++) begin
            if (i == 3) sw = 3'd3;
            cyc(1);
            chk("glitch_led", 32'(led8), 32'h1234);
            chk("glitch_idx", 32'(idx8), 32'h3);
        end

        // Freeze: browse snapshot, leave, re-enter for a fresh snapshot
        set_reg(4, 16'hBEEF);
        mode = 2'd1;
        cyc(2);
        chk("frz_entry", 32'(led8), 32'h1234);
        set_reg(4, 16'h0000);
        sw = 3'd4;
        cyc(10);
        chk("frz_led", 32'(led8), 32'hBEEF);
        chk("frz_idx", 32'(idx8), 32'h4);
        mode = 2'd0;
        cyc(1);
        chk("frz_exit", 32'(led8), 32'h0000);
        set_reg(4, 16'h4444);
        mode = 2'd1;
        cyc(2);
        set_reg(4, 16'h5555);
        cyc(2);
        chk("frz_resnap", 32'(led8), 32'h4444);
        mode = 2'd0;
        cyc(1);
        chk("frz_live", 32'(led8), 32'h5555);

        // Scan with wrap
        for (int i = 0; i < 8; i++) set_reg(i, 16'h0100 + 16'(i));
        mode = 2'd2;
        cyc(1);
        chk("scan_led0", 32'(led8), 32'h0100);
        chk("scan_idx0", 32'(idx8), 32'h0);
        chk("scan_err", 32'(err8), 32'h0);
        for (int s = 1; s <= 9; s++) begin
            cyc(9);
            chk("scan_hold", 32'(led8), 32'h0100 + 32'((s - 1) % 8));
            cyc(1);
            chk("scan_step", 32'(led8), 32'h0100 + 32'(s % 8));
            chk("scan_idx8", 32'(idx8), 32'(s % 8));
            chk("scan_idx6", 32'(idx6), 32'(s % 6));
        end

        // Watch: no pulse on entry, one pulse on change, none on select change
        mode = 2'd0;
        set_reg(2, 16'h0001); set_reg(3, 16'hAAAA);
        sw = 3'd2;
        cyc(10);
        mode = 2'd3;
        set_reg(2, 16'h0009);
        cyc(1);
        chk("watch_entry", 32'(pul8), 32'h0);
        cyc(2);
        chk("watch_quiet", 32'(pul8), 32'h0);
        set_reg(2, 16'h0002);
        cyc(1);
        chk("watch_pulse", 32'(pul8), 32'h1);
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            cyc(1);
            cnt += int'(pul8);
        end
        chk("watch_single", 32'(cnt), 32'h0);
        sw = 3'd3;
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            cyc(1);
            cnt += int'(pul8);
        end
        chk("watch_selchg", 32'(cnt), 32'h0);
        chk("watch_led", 32'(led8), 32'hAAAA);

        // Out of range on the 6-register build, then asynchronous reset mid-scan
        mode = 2'd0;
        set_reg(7, 16'h7777);
        sw = 3'd7;
        cyc(10);
        chk("oor_err6", 32'(err6), 32'h1);
        chk("oor_led6", 32'(led6), 32'h0);
        chk("oor_led8", 32'(led8), 32'h7777);
        chk("oor_err8", 32'(err8), 32'h0);
        mode = 2'd2;
        cyc(15);
        chk("pre_rst_idx8", 32'(idx8), 32'h1);
        chk("pre_rst_idx6", 32'(idx6), 32'h1);
        chk("pre_rst_err6", 32'(err6), 32'h0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_led8", 32'(led8), 32'h0);
        chk("arst_idx8", 32'(idx8), 32'h0);
        chk("arst_led6", 32'(led6), 32'h0);
        chk("arst_idx6", 32'(idx6), 32'h0);
        chk("arst_err6", 32'(err6), 32'h0);
        chk("arst_pul", 32'({pul8, pul6}), 32'h0);
        cyc(3);
        rst_n = 1'b1;

        // Randomised run against the history model
        hold = 0;
        for (int k = 0; k < NR; k++) begin
            if (hold == 0) begin
                mode = 2'($urandom_range(0, 3));
                hold = $urandom_range(1, 60);
            end
            hold--;
            if ($urandom_range(0, 7) == 0) sw = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 2) == 0) begin
                ri = $urandom_range(0, 7);
                set_reg(ri, $urandom_range(0, 1) == 0 ? 16'($urandom_range(0, 3)) : 16'($urandom));
            end
            h_sw[k] = sw; h_m[k] = mode; h_r[k] = regs;
            model_sel(k);
            cyc(1);
            model_out(k, 8, el, ei, ee, ep);
            chk("rnd_led8", 32'(led8), 32'(el));
            chk("rnd_idx8", 32'(idx8), 32'(ei));
            chk("rnd_err8", 32'(err8), 32'(ee));
            chk("rnd_pul8", 32'(pul8), 32'(ep));
            model_out(k, 6, el, ei, ee, ep);
            chk("rnd_led6", 32'(led6), 32'(el));
            chk("rnd_idx6", 32'(idx6), 32'(ei));
            chk("rnd_err6", 32'(err6), 32'(ee));
            chk("rnd_pul6", 32'(pul6), 32'(ep));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
